// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU operation codes, instruction classes and trap causes.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_NONE = 4'b1111;

    typedef enum logic [1:0] {
        TC_NONE    = 2'd0,
        TC_ILLEGAL = 2'd1,
        TC_BUS     = 2'd2
    } trap_t;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_ILLEGAL
    } iclass_t;

    // funct3 mapping shared by R-type and I-ALU; the caller decides the alternate forms
    function automatic logic [3:0] alu_op(input logic [2:0] f3,
                                          input logic       alt_sub,
                                          input logic       alt_sra);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt_sub ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt_sra ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_decode.sv
// Combinational instruction decode: class/legality, ALU operation, ALU operand
// select and writeback source. Illegal encodings decode to ALU_NONE with selects low.
module rv_decode
    import rv_ctrl_pkg::*;
(
    input  logic [31:0] i_ir,
    output iclass_t     o_cls,
    output logic [3:0]  o_alu_ctrl,
    output logic        o_alu_src,
    output logic        o_mem_to_reg
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_unused_ir;

    assign w_opcode    = i_ir[6:0];
    assign w_funct3    = i_ir[14:12];
    assign w_funct7    = i_ir[31:25];
    assign w_unused_ir = ^{i_ir[24:15], i_ir[11:7]};

    always_comb begin
        o_cls        = CL_ILLEGAL;
        o_alu_ctrl   = ALU_NONE;
        o_alu_src    = 1'b0;
        o_mem_to_reg = 1'b0;
        case (w_opcode)
            OP_R: begin
                o_cls      = CL_ALU;
                o_alu_ctrl = alu_op(w_funct3, w_funct7 == F7_ALT, w_funct7 == F7_ALT);
            end
            OP_IALU: begin
                // immediates have no SUB form; bit 30 only selects SRAI
                o_cls      = CL_ALU;
                o_alu_ctrl = alu_op(w_funct3, 1'b0, i_ir[30]);
                o_alu_src  = 1'b1;
            end
            OP_LOAD: begin
                if (w_funct3 == F3_WORD) begin
                    o_cls        = CL_LOAD;
                    o_alu_ctrl   = ALU_ADD;
                    o_alu_src    = 1'b1;
                    o_mem_to_reg = 1'b1;
                end
            end
            OP_STORE: begin
                if (w_funct3 == F3_WORD) begin
                    o_cls      = CL_STORE;
                    o_alu_ctrl = ALU_ADD;
                    o_alu_src  = 1'b1;
                end
            end
            OP_BRANCH: begin
                case (w_funct3)
                    F3_BEQ, F3_BNE: begin
                        o_cls      = CL_BRANCH;
                        o_alu_ctrl = ALU_SUB;
                    end
                    F3_BLT, F3_BGE: begin
                        o_cls      = CL_BRANCH;
                        o_alu_ctrl = ALU_SLT;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I subset control FSM with data-memory timeout trap and
// cycle / retired-instruction counters.
//   state  | meaning
//   FETCH  | request instruction, latch IR on ack
//   DECODE | legality check, illegal -> TRAP
//   EXEC   | ALU step; branches resolve and redirect PC here
//   MEM    | LW/SW access, bounded by TIMEOUT wait cycles
//   WB     | register write and PC advance
//   TRAP   | halted until reset
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      instr,
    input  logic             Zero,
    input  logic             Lt,
    input  logic             dmem_ack,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             loadPC,
    output logic             PCSrc,
    output logic             ALUSrc,
    output logic             MemToReg,
    output logic [3:0]       ALUCtrl,
    output logic [2:0]       state,
    output logic             halted,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           r_state, w_state_nxt;
    trap_t            r_trap, w_trap_nxt;
    logic [31:0]      r_ir;
    logic [7:0]       r_wait, w_wait_nxt;
    logic [CNT_W-1:0] r_cyc, r_ret;

    iclass_t          w_cls;
    logic [3:0]       w_alu_ctrl;
    logic             w_alu_src, w_mem_to_reg, w_br_taken, w_ctl_valid;

    rv_decode u_decode (
        .i_ir         (r_ir),
        .o_cls        (w_cls),
        .o_alu_ctrl   (w_alu_ctrl),
        .o_alu_src    (w_alu_src),
        .o_mem_to_reg (w_mem_to_reg)
    );

    always_comb begin
        case (r_ir[14:12])
            F3_BEQ:  w_br_taken = Zero;
            F3_BNE:  w_br_taken = !Zero;
            F3_BLT:  w_br_taken = Lt;
            default: w_br_taken = !Lt;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_trap_nxt  = r_trap;
        w_wait_nxt  = '0;
        imem_req    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        loadPC      = 1'b0;
        PCSrc       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_cls == CL_ILLEGAL) begin
                    w_state_nxt = ST_TRAP;
                    w_trap_nxt  = TC_ILLEGAL;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (w_cls)
                    CL_BRANCH: begin
                        loadPC      = 1'b1;
                        PCSrc       = w_br_taken;
                        w_state_nxt = ST_FETCH;
                    end
                    CL_LOAD, CL_STORE: w_state_nxt = ST_MEM;
                    default:           w_state_nxt = ST_WB;
                endcase
            end
            ST_MEM: begin
                MemRead  = (w_cls == CL_LOAD);
                MemWrite = (w_cls == CL_STORE);
                // an ack arriving on the last allowed wait cycle still completes the access
                if (dmem_ack) begin
                    if (w_cls == CL_STORE) begin
                        loadPC      = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_WB;
                    end
                end else if (r_wait == WAIT_LAST) begin
                    w_state_nxt = ST_TRAP;
                    w_trap_nxt  = TC_BUS;
                end else begin
                    w_wait_nxt = r_wait + 8'd1;
                end
            end
            ST_WB: begin
                RegWrite    = 1'b1;
                loadPC      = 1'b1;
                w_state_nxt = ST_FETCH;
            end
            ST_TRAP: ;
            default: w_state_nxt = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_FETCH;
            r_trap  <= TC_NONE;
            r_ir    <= '0;
            r_wait  <= '0;
            r_cyc   <= '0;
            r_ret   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_trap  <= w_trap_nxt;
            r_wait  <= w_wait_nxt;
            if (r_state == ST_FETCH && imem_ack) r_ir <= instr;
            if (r_state != ST_TRAP) begin
                r_cyc <= r_cyc + CNT_W'(1);
                if (loadPC) r_ret <= r_ret + CNT_W'(1);
            end
        end
    end

    assign w_ctl_valid = (r_state == ST_DECODE) || (r_state == ST_EXEC) ||
                         (r_state == ST_MEM)    || (r_state == ST_WB);
    assign ALUCtrl     = w_ctl_valid ? w_alu_ctrl : 4'b0000;
    assign ALUSrc      = w_ctl_valid & w_alu_src;
    assign MemToReg    = w_ctl_valid & w_mem_to_reg;
    assign state       = r_state;
    assign halted      = (r_state == ST_TRAP);
    assign trap_cause  = r_trap;
    assign cycle_cnt   = r_cyc;
    assign instret_cnt = r_ret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench: each instruction expands into an expected per-cycle trace
// derived from the instruction's semantics, checked cycle by cycle, plus literal pins.
module tb_multicycle_ctrl;

    localparam int TO = 15;
    localparam int CW = 32;
    localparam int NTRAP = 3;

    logic          clk = 1'b0, rst = 1'b0;
    logic          imem_ack = 1'b0, Zero = 1'b0, Lt = 1'b0, dmem_ack = 1'b0;
    logic [31:0]   instr = '0;
    logic          imem_req, MemRead, MemWrite, RegWrite, loadPC, PCSrc, ALUSrc, MemToReg;
    logic [3:0]    ALUCtrl;
    logic [2:0]    state;
    logic          halted;
    logic [1:0]    trap_cause;
    logic [CW-1:0] cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
        .Zero(Zero), .Lt(Lt), .dmem_ack(dmem_ack), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .loadPC(loadPC), .PCSrc(PCSrc), .ALUSrc(ALUSrc),
        .MemToReg(MemToReg), .ALUCtrl(ALUCtrl), .state(state), .halted(halted),
        .trap_cause(trap_cause), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    typedef struct {
        logic [2:0] st;
        logic       iack, dack;
        logic       req, rd, wr, rw, lpc, pcs, asrc, m2r, halt;
        logic [3:0] alu;
        logic [1:0] tc;
    } cyc_t;

    cyc_t        q[$];
    int          n_chk = 0, n_err = 0;
    logic [31:0] exp_cyc = 0, exp_ret = 0;
    logic [31:0] cur_instr;
    logic        cur_z, cur_l;
    int          obs_n, obs_rd, obs_wr;
    logic [31:0] obs_seq;
    logic [3:0]  obs_alu_exec;
    logic        obs_pcs_exec, obs_lpc_exec, obs_m2r_mem;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    function automatic logic m_legal(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        op = ins[6:0];
        f3 = ins[14:12];
        return (op == 7'b0110011) || (op == 7'b0010011) ||
               (op == 7'b0000011 && f3 == 3'd2) || (op == 7'b0100011 && f3 == 3'd2) ||
               (op == 7'b1100011 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5));
    endfunction

    // ALU operation an instruction needs, from its mnemonic meaning
    function automatic logic [3:0] m_alu(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        logic       is_r, alt;
        op   = ins[6:0];
        f3   = ins[14:12];
        is_r = (op == 7'b0110011);
        alt  = is_r ? (ins[31:25] == 7'b0100000) : ins[30];
        if (!m_legal(ins)) return 4'hF;
        if (op == 7'b0000011 || op == 7'b0100011) return 4'h2;
        if (op == 7'b1100011) return (f3 < 3'd2) ? 4'h6 : 4'h4;
        case (f3)
            3'd0:    return (is_r && alt) ? 4'h6 : 4'h2;
            3'd1:    return 4'h9;
            3'd2:    return 4'h4;
            3'd4:    return 4'h5;
            3'd5:    return alt ? 4'hA : 4'h8;
            3'd6:    return 4'h1;
            3'd7:    return 4'h0;
            default: return 4'hF;
        endcase
    endfunction

    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t c;
        c.st = st; c.iack = 0; c.dack = 0; c.req = 0; c.rd = 0; c.wr = 0; c.rw = 0;
        c.lpc = 0; c.pcs = 0; c.asrc = 0; c.m2r = 0; c.halt = 0; c.alu = 0; c.tc = 0;
        return c;
    endfunction

    task automatic push_trap(input logic [1:0] cause);
        cyc_t c;
        for (int i = 0; i < NTRAP; i++) begin
            c = blank(3'd5);
            c.halt = 1;
            c.tc = cause;
            q.push_back(c);
        end
    endtask

    // Expected trace: fwait fetch stalls, dly data-memory wait cycles before ack
    task automatic build(input logic [31:0] ins, input logic z, input logic l,
                         input int fwait, input int dly);
        cyc_t c;
        logic [6:0] op;
        logic legal, is_ld, is_st, is_br, asrc, m2r, taken;
        logic [3:0] alu;
        logic [2:0] f3;
        cur_instr = ins; cur_z = z; cur_l = l;
        op = ins[6:0]; f3 = ins[14:12];
        legal = m_legal(ins);
        is_ld = legal && op == 7'b0000011;
        is_st = legal && op == 7'b0100011;
        is_br = legal && op == 7'b1100011;
        alu   = m_alu(ins);
        asrc  = legal && (op == 7'b0010011 || is_ld || is_st);
        m2r   = is_ld;
        taken = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : (f3 == 3'd4) ? l : !l;
        for (int i = 0; i <= fwait; i++) begin
            c = blank(3'd0); c.req = 1; c.iack = (i == fwait); q.push_back(c);
        end
        c = blank(3'd1); c.alu = alu; c.asrc = asrc; c.m2r = m2r; q.push_back(c);
        if (!legal) begin
            push_trap(2'd1);
            return;
        end
        c = blank(3'd2); c.alu = alu; c.asrc = asrc; c.m2r = m2r;
        if (is_br) begin
            c.lpc = 1; c.pcs = taken; q.push_back(c);
            return;
        end
        q.push_back(c);
        if (is_ld || is_st) begin
            for (int i = 0; i <= dly && i < TO; i++) begin
                c = blank(3'd3); c.alu = alu; c.asrc = asrc; c.m2r = m2r;
                c.rd = is_ld; c.wr = is_st; c.dack = (i == dly);
                c.lpc = is_st && (i == dly);
                q.push_back(c);
            end
            if (dly >= TO) begin
                push_trap(2'd2);
                return;
            end
            if (is_st) return;
        end
        c = blank(3'd4); c.alu = alu; c.asrc = asrc; c.m2r = m2r; c.rw = 1; c.lpc = 1;
        q.push_back(c);
    endtask

    task automatic run(input int nmax);
        obs_n = 0; obs_rd = 0; obs_wr = 0; obs_seq = 0; obs_alu_exec = 4'hX;
        obs_pcs_exec = 1'bX; obs_lpc_exec = 1'b0; obs_m2r_mem = 1'b0;
        for (int i = 0; i < q.size() && i < nmax; i++) begin
            @(negedge clk);
            imem_ack = q[i].iack; dmem_ack = q[i].dack;
            instr = cur_instr; Zero = cur_z; Lt = cur_l;
            #1;
            chk("state", state, q[i].st);
            chk("imem_req", imem_req, q[i].req);
            chk("MemRead", MemRead, q[i].rd);
            chk("MemWrite", MemWrite, q[i].wr);
            chk("RegWrite", RegWrite, q[i].rw);
            chk("loadPC", loadPC, q[i].lpc);
            chk("PCSrc", PCSrc, q[i].pcs);
            chk("ALUSrc", ALUSrc, q[i].asrc);
            chk("MemToReg", MemToReg, q[i].m2r);
            chk("ALUCtrl", ALUCtrl, q[i].alu);
            chk("halted", halted, q[i].halt);
            chk("trap_cause", trap_cause, q[i].tc);
            chk("cycle_cnt", cycle_cnt, exp_cyc);
            chk("instret_cnt", instret_cnt, exp_ret);
            obs_n++;
            obs_seq = {obs_seq[27:0], 1'b0, state};
            if (MemRead) obs_rd++;
            if (MemWrite) obs_wr++;
            if (state == 3'd2) begin
                obs_alu_exec = ALUCtrl; obs_pcs_exec = PCSrc; obs_lpc_exec = loadPC;
            end
            if (state == 3'd3) obs_m2r_mem = MemToReg;
            if (q[i].st != 3'd5) begin
                exp_cyc++;
                if (q[i].lpc) exp_ret++;
            end
        end
        q.delete();
    endtask

    task automatic pin_after();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 0; imem_ack = 0; dmem_ack = 0;
        @(posedge clk);
        #1;
        rst = 1;
        exp_cyc = 0; exp_ret = 0;
        chk({tag, "_state"}, state, 0);
        chk({tag, "_MemRead"}, MemRead, 0);
        chk({tag, "_MemWrite"}, MemWrite, 0);
        chk({tag, "_RegWrite"}, RegWrite, 0);
        chk({tag, "_loadPC"}, loadPC, 0);
        chk({tag, "_imem_req"}, imem_req, 1);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_trap_cause"}, trap_cause, 0);
        chk({tag, "_cycle_cnt"}, cycle_cnt, 0);
        chk({tag, "_instret_cnt"}, instret_cnt, 0);
    endtask

    logic [31:0] br_tab[7] = '{32'h00208063, 32'h00208063, 32'h0020C063, 32'h0020C063,
                               32'h0020D063, 32'h0020D063, 32'h00209063};
    logic [1:0]  br_zl[7]  = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10};
    logic [31:0] alu_tab[11] = '{32'h402081B3, 32'h002091B3, 32'h0020A1B3, 32'h0020B1B3,
                                 32'h0020C1B3, 32'h0020E1B3, 32'h0020F1B3, 32'h00508193,
                                 32'h40008193, 32'h4010D193, 32'h0010D193};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset("por");

        build(32'h002081B3, 0, 0, 0, 0);
        run(99);
        chk("add_seq", obs_seq, 32'h00000124);
        chk("add_alu", obs_alu_exec, 4'b0010);
        pin_after();
        chk("add_instret", instret_cnt, 1);
        chk("add_back_fetch", state, 0);

        build(32'h0000A183, 0, 0, 0, 3);
        run(99);
        chk("lw_cycles", obs_n, 8);
        chk("lw_memread_cycles", obs_rd, 4);
        chk("lw_seq", obs_seq, 32'h01233334);
        chk("lw_memtoreg", obs_m2r_mem, 1);

        build(32'h00209063, 0, 0, 0, 0);
        run(99);
        chk("bne_seq", obs_seq, 32'h00000012);
        chk("bne_alu", obs_alu_exec, 4'b0110);
        chk("bne_pcsrc", obs_pcs_exec, 1);
        chk("bne_loadpc", obs_lpc_exec, 1);
        pin_after();
        chk("bne_no_wb", state, 0);

        for (int i = 0; i < 7; i++) begin
            build(br_tab[i], br_zl[i][1], br_zl[i][0], 0, 0);
            run(99);
        end

        build(32'h4020D1B3, 0, 0, 0, 0);
        run(99);
        chk("sra_alu", obs_alu_exec, 4'b1010);
        build(32'h0020D1B3, 0, 0, 0, 0);
        run(99);
        chk("srl_alu", obs_alu_exec, 4'b1000);

        for (int i = 0; i < 11; i++) begin
            build(alu_tab[i], 0, 0, i % 3, 0);
            run(99);
        end

        build(32'h0020A023, 0, 0, 0, 0);
        run(99);
        build(32'h0020A023, 0, 0, 1, TO - 1);
        run(99);
        chk("sw_late_ack_writes", obs_wr, TO);
        pin_after();
        chk("sw_late_ack_state", state, 0);
        chk("sw_late_ack_cause", trap_cause, 0);

        build(32'h0020A023, 0, 0, 0, 1000);
        run(99);
        chk("sw_timeout_writes", obs_wr, TO);
        pin_after();
        chk("sw_timeout_cause", trap_cause, 2);
        chk("sw_timeout_halted", halted, 1);
        chk("sw_timeout_memwrite", MemWrite, 0);
        do_reset("rst_after_bus");

        build(32'hFFFFFFFF, 0, 0, 0, 0);
        run(99);
        chk("ill_seq", obs_seq, 32'h00001555);
        chk("ill_cause", trap_cause, 1);
        do_reset("rst_after_ill");

        build(32'h0000B183, 0, 0, 0, 0);
        run(99);
        chk("lw_bad_f3_cause", trap_cause, 1);
        do_reset("rst_after_badlw");

        build(32'h0000A183, 0, 0, 0, 10);
        run(5);
        chk("midlw_in_mem", MemRead, 1);
        do_reset("rst_mid_lw");

        build(32'h002081B3, 0, 0, 2, 0);
        run(99);
        pin_after();
        chk("post_reset_instret", instret_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, is the maximum memory wait cycles before a bus-error trap; legal range 1..255.
REQ-002 Parameter CNT_W, default 32, is the width of the performance counters.
REQ-003 Port clk, input, 1, sole clock; all state changes on rising edge.
REQ-004 Port rst, input, 1, reset; synchronous, active-low (0 = reset).
REQ-005 Ports imem_req/imem_ack: output 1, fetch request held until ack; input 1, instruction valid this cycle.
REQ-006 Port instr, input, 32, instruction word; sampled only when imem_req and imem_ack are both high.
REQ-007 Ports Zero/Lt, input, 1 each; ALU result zero / signed less-than, valid in EXEC.
REQ-008 Port dmem_ack, input, 1, data-memory access complete.
REQ-009 Outputs MemRead, MemWrite, RegWrite, loadPC, PCSrc, ALUSrc, MemToReg, 1 each, datapath controls.
REQ-010 Outputs ALUCtrl 4 (operation), state 3 (current state), halted 1, trap_cause 2 (0 none, 1 illegal, 2 bus timeout).
REQ-011 Outputs cycle_cnt and instret_cnt, CNT_W each; cycles since reset / retired instructions.

Function
REQ-012 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 go to TRAP.
REQ-013 FETCH: imem_req=1; on imem_ack, latch instr into internal IR, go to DECODE; otherwise stay (no timeout in FETCH).
REQ-014 DECODE: legal opcodes R 0110011, I-ALU 0010011, LW 0000011 (funct3 010), SW 0100011 (funct3 010), BRANCH 1100011 (funct3 000/001/100/101); any other -> TRAP, trap_cause=1; legal -> EXEC.
REQ-015 ALUCtrl (decoded from IR): AND 0000, OR 0001, ADD 0010, SLT 0100, XOR 0101, SUB 0110, SRL 1000, SLL 1001, SRA 1010; unused 1111.
REQ-016 R-type: funct7=0100000 selects SUB (funct3 000) or SRA (funct3 101); I-ALU: SUB never, SRAI when IR[30]=1 and funct3 101.
REQ-017 LW/SW -> ADD; BRANCH -> SUB for BEQ/BNE, SLT for BLT/BGE.
REQ-018 ALUSrc=1 for I-ALU, LW, SW; 0 otherwise. MemToReg=1 only for LW.
REQ-019 EXEC: branches assert loadPC=1 for one cycle with PCSrc = Zero (BEQ), !Zero (BNE), Lt (BLT), !Lt (BGE), then FETCH; LW/SW -> MEM; ALU ops -> WB.
REQ-020 MEM: MemRead (LW) or MemWrite (SW) held high until dmem_ack; never both high.
REQ-021 MEM wait counter counts cycles without ack; at count = TIMEOUT with no ack -> TRAP, trap_cause=2, access deasserted next cycle.
REQ-022 ack in the same cycle as the timeout reached wins (access completes).
REQ-023 SW on ack: loadPC=1, PCSrc=0, -> FETCH; LW on ack -> WB.
REQ-024 WB: RegWrite=1 and loadPC=1 with PCSrc=0 for exactly one cycle, -> FETCH.
REQ-025 All control outputs decoded from registered state and IR; zero in any state not listed as asserting them.
REQ-026 instret_cnt increments on every cycle with loadPC=1; cycle_cnt increments every non-reset cycle; both wrap modulo 2^CNT_W.
REQ-027 TRAP: halted=1, all memory/writeback controls 0, counters frozen, exits only via reset.

Reset
REQ-028 With rst=0 at a clock edge: state=FETCH, IR=0, wait counter=0, counters=0, trap_cause=0, halted=0.
REQ-029 Reset mid-access aborts the access; MemRead/MemWrite/RegWrite/loadPC are 0 in the cycle after the reset edge.

Structure
REQ-030 State codes, opcode and ALUCtrl encodings, and trap-cause values reside in a shared package rv_ctrl_pkg.
REQ-031 ALUCtrl/ALUSrc/MemToReg/legality decode is a combinational sub-module rv_decode; FSM, counters and timeout remain in multicycle_ctrl.

Verification
REQ-032 ADD x3,x1,x2 (0x002081B3), ack immediately, dmem idle -> states 0,1,2,4,0; ALUCtrl=0010; RegWrite=loadPC=1 in WB only; instret_cnt=1.
REQ-033 LW (0x0000A183), dmem_ack after 3 wait cycles -> MemRead high 4 cycles, MemToReg=1, then WB; total 8 cycles.
REQ-034 BNE with Zero=0 -> EXEC asserts loadPC=1, PCSrc=1, ALUCtrl=0110, no WB state visited.
REQ-035 SW with dmem_ack never asserted, TIMEOUT=15 -> TRAP after 15 wait cycles, trap_cause=2, halted=1, MemWrite=0 thereafter.
REQ-036 instr 0xFFFFFFFF -> TRAP from DECODE, trap_cause=1; rst=0 one cycle -> FETCH, counters 0.
REQ-037 SRA (funct7 0100000, funct3 101) -> ALUCtrl=1010; SRL (funct7 0) -> 1000.
